// File: rtl/tri_bbox_setup.sv
// Triangle setup: viewport vertices to screen pixels, clamped bounding box,
// doubled signed area and cull decision, one triangle in flight at a time.
module tri_bbox_setup #(
  parameter int VIEWPORT_H_POSITION_WIDTH = 18,
  parameter int VIEWPORT_W_POSITION_WIDTH = 20,
  parameter int C_WIDTH                   = 18,
  parameter int COLOR_WIDTH               = 16,
  parameter int FRAC_BITS                 = 14,
  parameter int SCREEN_W                  = 320,
  parameter int SCREEN_H                  = 180,
  parameter int PIX_SCALE_X               = 160,
  parameter int PIX_SCALE_Y               = 90,
  parameter int PIX_WIDTH                 = 12,
  parameter int CULL_BACK                 = 0,
  parameter int COUNT_WIDTH               = 16
) (
  input  logic                                        clk_in,
  input  logic                                        rst_in,
  input  logic                                        valid_in,
  output logic                                        ready_out,
  input  logic [2:0][VIEWPORT_H_POSITION_WIDTH-1:0]   viewport_x_positions_in,
  input  logic [2:0][VIEWPORT_W_POSITION_WIDTH-1:0]   viewport_y_positions_in,
  input  logic [2:0][C_WIDTH:0]                       z_depth_in,
  input  logic [COLOR_WIDTH-1:0]                      color_in,
  output logic                                        valid_out,
  input  logic                                        ready_in,
  output logic [2:0][PIX_WIDTH-1:0]                   pix_x_out,
  output logic [2:0][PIX_WIDTH-1:0]                   pix_y_out,
  output logic [$clog2(SCREEN_W)-1:0]                 x_min_out,
  output logic [$clog2(SCREEN_W)-1:0]                 x_max_out,
  output logic [$clog2(SCREEN_H)-1:0]                 y_min_out,
  output logic [$clog2(SCREEN_H)-1:0]                 y_max_out,
  output logic [2*PIX_WIDTH+2:0]                      area_out,
  output logic [2:0][C_WIDTH:0]                       z_depth_out,
  output logic [COLOR_WIDTH-1:0]                      color_out,
  output logic [COUNT_WIDTH-1:0]                      tri_out_count_out,
  output logic [COUNT_WIDTH-1:0]                      tri_culled_count_out
);

  localparam int XW  = VIEWPORT_H_POSITION_WIDTH;
  localparam int YW  = VIEWPORT_W_POSITION_WIDTH;
  localparam int PW  = PIX_WIDTH;
  localparam int DW  = PW + 1;
  localparam int AW  = 2 * PW + 3;
  localparam int PXW = XW + $clog2(PIX_SCALE_X + 1) + 1;
  localparam int PYW = YW + $clog2(PIX_SCALE_Y + 1) + 1;
  localparam int OW  = ((PXW > PYW) ? PXW : PYW) + 2;
  localparam int XBW = $clog2(SCREEN_W);
  localparam int YBW = $clog2(SCREEN_H);

  localparam logic signed [PXW-1:0] SCALE_X = PXW'(PIX_SCALE_X);
  localparam logic signed [PYW-1:0] SCALE_Y = PYW'(PIX_SCALE_Y);
  localparam logic signed [OW-1:0]  HALF_W  = OW'(SCREEN_W / 2);
  localparam logic signed [OW-1:0]  HALF_H  = OW'(SCREEN_H / 2);
  localparam logic signed [OW-1:0]  PIX_MAX = OW'(2 ** (PW - 1) - 1);
  localparam logic signed [OW-1:0]  PIX_MIN = ~PIX_MAX;
  localparam logic signed [PW-1:0]  X_LAST  = PW'(SCREEN_W - 1);
  localparam logic signed [PW-1:0]  Y_LAST  = PW'(SCREEN_H - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCALE, S_OFFSET, S_BBOX, S_AREA, S_DECIDE, S_HOLD
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_ready;
  logic   r_valid;

  logic [2:0][XW-1:0]          r_x;
  logic [2:0][YW-1:0]          r_y;
  logic [2:0][C_WIDTH:0]       r_z;
  logic [COLOR_WIDTH-1:0]      r_color;
  logic signed [PXW-1:0]       r_px [3];
  logic signed [PYW-1:0]       r_py [3];
  logic signed [PW-1:0]        r_pix_x [3];
  logic signed [PW-1:0]        r_pix_y [3];
  logic signed [PW-1:0]        r_xmin, r_xmax, r_ymin, r_ymax;
  logic signed [DW-1:0]        r_d1x, r_d1y, r_d2x, r_d2y;
  logic signed [AW-1:0]        r_area;

  logic [2:0][PW-1:0]          r_pix_x_o, r_pix_y_o;
  logic [XBW-1:0]              r_xmin_o, r_xmax_o;
  logic [YBW-1:0]              r_ymin_o, r_ymax_o;
  logic [AW-1:0]               r_area_o;
  logic [2:0][C_WIDTH:0]       r_z_o;
  logic [COLOR_WIDTH-1:0]      r_color_o;
  logic [COUNT_WIDTH-1:0]      r_cnt_out, r_cnt_cull;

  logic signed [PW-1:0]        w_off_x [3];
  logic signed [PW-1:0]        w_off_y [3];
  logic                        w_cull;

  function automatic logic signed [PW-1:0] sat_pix(input logic signed [OW-1:0] v);
    if (v > PIX_MAX)      return PIX_MAX[PW-1:0];
    else if (v < PIX_MIN) return PIX_MIN[PW-1:0];
    else                  return v[PW-1:0];
  endfunction

  function automatic logic signed [PW-1:0] min3(input logic signed [PW-1:0] a, b, c);
    logic signed [PW-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [PW-1:0] max3(input logic signed [PW-1:0] a, b, c);
    logic signed [PW-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic [XBW-1:0] clamp_x(input logic signed [PW-1:0] v);
    if (v[PW-1])        return '0;
    else if (v > X_LAST) return X_LAST[XBW-1:0];
    else                return v[XBW-1:0];
  endfunction

  function automatic logic [YBW-1:0] clamp_y(input logic signed [PW-1:0] v);
    if (v[PW-1])        return '0;
    else if (v > Y_LAST) return Y_LAST[YBW-1:0];
    else                return v[YBW-1:0];
  endfunction

  // Arithmetic shift floors toward -inf; screen y grows downward, hence the flip.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_off_x[i] = sat_pix(OW'(r_px[i] >>> FRAC_BITS) + HALF_W);
      w_off_y[i] = sat_pix(HALF_H - OW'(r_py[i] >>> FRAC_BITS));
    end
  end

  always_comb begin
    w_cull = r_xmax[PW-1] || (r_xmin > X_LAST) ||
             r_ymax[PW-1] || (r_ymin > Y_LAST) ||
             (r_area == '0) || ((CULL_BACK != 0) && r_area[AW-1]);
  end

  // Handshakes: a transfer happens on a clock edge where valid and ready are
  // both high; ready_out is high only in IDLE, valid_out only in HOLD.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (valid_in) w_next = S_SCALE;
      S_SCALE:  w_next = S_OFFSET;
      S_OFFSET: w_next = S_BBOX;
      S_BBOX:   w_next = S_AREA;
      S_AREA:   w_next = S_DECIDE;
      S_DECIDE: w_next = w_cull ? S_IDLE : S_HOLD;
      S_HOLD:   if (ready_in) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_IDLE);
      r_valid <= (w_next == S_HOLD);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_x <= '0; r_y <= '0; r_z <= '0; r_color <= '0;
      for (int i = 0; i < 3; i++) begin
        r_px[i] <= '0; r_py[i] <= '0; r_pix_x[i] <= '0; r_pix_y[i] <= '0;
      end
      r_xmin <= '0; r_xmax <= '0; r_ymin <= '0; r_ymax <= '0;
      r_d1x <= '0; r_d1y <= '0; r_d2x <= '0; r_d2y <= '0;
      r_area <= '0;
      r_pix_x_o <= '0; r_pix_y_o <= '0;
      r_xmin_o <= '0; r_xmax_o <= '0; r_ymin_o <= '0; r_ymax_o <= '0;
      r_area_o <= '0; r_z_o <= '0; r_color_o <= '0;
      r_cnt_out <= '0; r_cnt_cull <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (valid_in) begin
          r_x     <= viewport_x_positions_in;
          r_y     <= viewport_y_positions_in;
          r_z     <= z_depth_in;
          r_color <= color_in;
        end
        S_SCALE: for (int i = 0; i < 3; i++) begin
          r_px[i] <= PXW'($signed(r_x[i])) * SCALE_X;
          r_py[i] <= PYW'($signed(r_y[i])) * SCALE_Y;
        end
        S_OFFSET: for (int i = 0; i < 3; i++) begin
          r_pix_x[i] <= w_off_x[i];
          r_pix_y[i] <= w_off_y[i];
        end
        S_BBOX: begin
          r_xmin <= min3(r_pix_x[0], r_pix_x[1], r_pix_x[2]);
          r_xmax <= max3(r_pix_x[0], r_pix_x[1], r_pix_x[2]);
          r_ymin <= min3(r_pix_y[0], r_pix_y[1], r_pix_y[2]);
          r_ymax <= max3(r_pix_y[0], r_pix_y[1], r_pix_y[2]);
          r_d1x  <= DW'(r_pix_x[1]) - DW'(r_pix_x[0]);
          r_d1y  <= DW'(r_pix_y[1]) - DW'(r_pix_y[0]);
          r_d2x  <= DW'(r_pix_x[2]) - DW'(r_pix_x[0]);
          r_d2y  <= DW'(r_pix_y[2]) - DW'(r_pix_y[0]);
        end
        S_AREA: r_area <= AW'(r_d1x) * AW'(r_d2y) - AW'(r_d2x) * AW'(r_d1y);
        S_DECIDE: begin
          if (w_cull) begin
            r_cnt_cull <= r_cnt_cull + COUNT_WIDTH'(1);
          end else begin
            for (int i = 0; i < 3; i++) begin
              r_pix_x_o[i] <= r_pix_x[i];
              r_pix_y_o[i] <= r_pix_y[i];
            end
            r_xmin_o  <= clamp_x(r_xmin);
            r_xmax_o  <= clamp_x(r_xmax);
            r_ymin_o  <= clamp_y(r_ymin);
            r_ymax_o  <= clamp_y(r_ymax);
            r_area_o  <= r_area;
            r_z_o     <= r_z;
            r_color_o <= r_color;
            r_cnt_out <= r_cnt_out + COUNT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_out            = r_ready;
  assign valid_out            = r_valid;
  assign pix_x_out            = r_pix_x_o;
  assign pix_y_out            = r_pix_y_o;
  assign x_min_out            = r_xmin_o;
  assign x_max_out            = r_xmax_o;
  assign y_min_out            = r_ymin_o;
  assign y_max_out            = r_ymax_o;
  assign area_out             = r_area_o;
  assign z_depth_out          = r_z_o;
  assign color_out            = r_color_o;
  assign tri_out_count_out    = r_cnt_out;
  assign tri_culled_count_out = r_cnt_cull;

endmodule

// File: tb/tb_tri_bbox_setup.sv
// Bench for tri_bbox_setup: a default instance and a back-face-culling instance
// share data inputs; the selected one gets valid_in and is checked.
module tb_tri_bbox_setup;

  localparam int RW = 206;

  typedef struct {
    int x[3]; int y[3];
    bit cb;   bit emit;
    int px[3]; int py[3];
    int xmin; int xmax; int ymin; int ymax; int area;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, tb_valid, sel, ready_in;
  logic [2:0][17:0] x_in;
  logic [2:0][19:0] y_in;
  logic [2:0][18:0] z_in;
  logic [15:0]      col_in;
  logic va_in, vb_in;
  assign va_in = tb_valid & ~sel;
  assign vb_in = tb_valid & sel;

  logic ready_a, valid_a, ready_b, valid_b;
  logic [2:0][11:0] pixx_a, pixy_a, pixx_b, pixy_b;
  logic [8:0] xmin_a, xmax_a, xmin_b, xmax_b;
  logic [7:0] ymin_a, ymax_a, ymin_b, ymax_b;
  logic [26:0] area_a, area_b;
  logic [2:0][18:0] z_a, z_b;
  logic [15:0] col_a, col_b, cnto_a, cntc_a, cnto_b, cntc_b;

  tri_bbox_setup u_dut_a (
    .clk_in(clk), .rst_in(rst), .valid_in(va_in), .ready_out(ready_a),
    .viewport_x_positions_in(x_in), .viewport_y_positions_in(y_in),
    .z_depth_in(z_in), .color_in(col_in), .valid_out(valid_a), .ready_in(ready_in),
    .pix_x_out(pixx_a), .pix_y_out(pixy_a), .x_min_out(xmin_a), .x_max_out(xmax_a),
    .y_min_out(ymin_a), .y_max_out(ymax_a), .area_out(area_a), .z_depth_out(z_a),
    .color_out(col_a), .tri_out_count_out(cnto_a), .tri_culled_count_out(cntc_a)
  );

  tri_bbox_setup #(.CULL_BACK(1)) u_dut_b (
    .clk_in(clk), .rst_in(rst), .valid_in(vb_in), .ready_out(ready_b),
    .viewport_x_positions_in(x_in), .viewport_y_positions_in(y_in),
    .z_depth_in(z_in), .color_in(col_in), .valid_out(valid_b), .ready_in(ready_in),
    .pix_x_out(pixx_b), .pix_y_out(pixy_b), .x_min_out(xmin_b), .x_max_out(xmax_b),
    .y_min_out(ymin_b), .y_max_out(ymax_b), .area_out(area_b), .z_depth_out(z_b),
    .color_out(col_b), .tri_out_count_out(cnto_b), .tri_culled_count_out(cntc_b)
  );

  logic [RW-1:0] res_a, res_b, m_res;
  logic m_ready, m_valid;
  logic [15:0] m_cnto, m_cntc;
  assign res_a   = {pixx_a, pixy_a, xmin_a, xmax_a, ymin_a, ymax_a, area_a, z_a, col_a};
  assign res_b   = {pixx_b, pixy_b, xmin_b, xmax_b, ymin_b, ymax_b, area_b, z_b, col_b};
  assign m_res   = sel ? res_b : res_a;
  assign m_ready = sel ? ready_b : ready_a;
  assign m_valid = sel ? valid_b : valid_a;
  assign m_cnto  = sel ? cnto_b : cnto_a;
  assign m_cntc  = sel ? cntc_b : cntc_a;

  int n_cmp = 0;
  int n_fail = 0;
  logic [RW-1:0] exp_q[$];
  int exp_out[2];
  int exp_cull[2];
  vec_t vt[7];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_res(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model in plain integer arithmetic.
  function automatic int fdiv(input int t);
    if (t >= 0) return t / 16384;
    else        return -((-t + 16383) / 16384);
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic vec_t model(input int x[3], input int y[3], input bit cb);
    vec_t v;
    int xmn, xmx, ymn, ymx;
    v.x = x; v.y = y; v.cb = cb;
    for (int i = 0; i < 3; i++) begin
      v.px[i] = clampi(fdiv(x[i] * 160) + 160, -2048, 2047);
      v.py[i] = clampi(90 - fdiv(y[i] * 90), -2048, 2047);
    end
    xmn = v.px[0]; xmx = v.px[0]; ymn = v.py[0]; ymx = v.py[0];
    for (int i = 1; i < 3; i++) begin
      if (v.px[i] < xmn) xmn = v.px[i];
      if (v.px[i] > xmx) xmx = v.px[i];
      if (v.py[i] < ymn) ymn = v.py[i];
      if (v.py[i] > ymx) ymx = v.py[i];
    end
    v.area = (v.px[1] - v.px[0]) * (v.py[2] - v.py[0]) - (v.px[2] - v.px[0]) * (v.py[1] - v.py[0]);
    v.emit = !(xmx < 0 || xmn > 319 || ymx < 0 || ymn > 179 || v.area == 0 || (cb && v.area < 0));
    v.xmin = clampi(xmn, 0, 319); v.xmax = clampi(xmx, 0, 319);
    v.ymin = clampi(ymn, 0, 179); v.ymax = clampi(ymx, 0, 179);
    return v;
  endfunction

  function automatic vec_t mk(input int x0, x1, x2, y0, y1, y2, input bit cb, emit,
                              input int px0, px1, px2, py0, py1, py2,
                              input int xmn, xmx, ymn, ymx, area);
    vec_t v;
    v.x[0] = x0; v.x[1] = x1; v.x[2] = x2;
    v.y[0] = y0; v.y[1] = y1; v.y[2] = y2;
    v.cb = cb; v.emit = emit;
    v.px[0] = px0; v.px[1] = px1; v.px[2] = px2;
    v.py[0] = py0; v.py[1] = py1; v.py[2] = py2;
    v.xmin = xmn; v.xmax = xmx; v.ymin = ymn; v.ymax = ymx; v.area = area;
    return v;
  endfunction

  function automatic logic [RW-1:0] pack_res(input vec_t v, input logic [2:0][18:0] z,
                                             input logic [15:0] c);
    logic [2:0][11:0] a, b;
    for (int i = 0; i < 3; i++) begin
      a[i] = 12'(v.px[i]);
      b[i] = 12'(v.py[i]);
    end
    return {a, b, 9'(v.xmin), 9'(v.xmax), 8'(v.ymin), 8'(v.ymax), 27'(v.area), z, c};
  endfunction

  // Scoreboard: pop on every output transfer (valid_out && ready_in at the edge).
  always @(negedge clk) begin
    if (!rst && m_valid && ready_in) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_output: got %h expected none", m_res);
      end else begin
        chk_res("output_data", m_res, exp_q.pop_front());
      end
    end
  end

  task automatic run_vec(input vec_t v, input int hold);
    logic [2:0][18:0] z;
    logic [15:0] c;
    logic [RW-1:0] e;
    int lat;
    bit done;
    sel = v.cb;
    for (int i = 0; i < 3; i++) begin
      x_in[i] = 18'(v.x[i]);
      y_in[i] = 20'(v.y[i]);
      z[i]    = 19'($urandom);
    end
    c = 16'($urandom);
    z_in = z; col_in = c;
    e = pack_res(v, z, c);
    tb_valid = 1'b1;
    chk("ready_before_accept", m_ready, 1);
    @(posedge clk); #1;
    tb_valid = 1'b0;
    chk("ready_low_after_accept", m_ready, 0);
    if (v.emit) exp_q.push_back(e);
    lat = 0; done = 0;
    while (!done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (m_valid || m_ready) done = 1;
    end
    chk("latency", lat, 5);
    if (v.emit) begin
      chk("valid_out_rise", m_valid, 1);
      exp_out[sel]++;
      for (int k = 0; k < hold; k++) begin
        tb_valid = k[0];
        for (int i = 0; i < 3; i++) begin
          x_in[i] = 18'($urandom); y_in[i] = 20'($urandom); z_in[i] = 19'($urandom);
        end
        col_in = 16'($urandom);
        @(posedge clk); #1;
        chk("hold_valid", m_valid, 1);
        chk("hold_ready", m_ready, 0);
        chk_res("hold_data", m_res, e);
      end
      tb_valid = 1'b0;
      ready_in = 1'b1;
      @(posedge clk); #1;
      ready_in = 1'b0;
      chk("valid_fall", m_valid, 0);
      chk("ready_rise", m_ready, 1);
    end else begin
      chk("cull_no_valid", m_valid, 0);
      exp_cull[sel]++;
    end
    chk("out_count", m_cnto, 16'(exp_out[sel]));
    chk("cull_count", m_cntc, 16'(exp_cull[sel]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int rx[3], ry[3];
    bit lost;
    rst = 1'b1; tb_valid = 1'b0; sel = 1'b0; ready_in = 1'b0;
    x_in = '0; y_in = '0; z_in = '0; col_in = '0;
    exp_out[0] = 0; exp_out[1] = 0; exp_cull[0] = 0; exp_cull[1] = 0;

    vt[0] = mk(0, 8192, 0,   0, 0, 8192,  0, 1, 160, 240, 160, 90, 90, 45, 160, 240, 45, 90, -3600);
    vt[1] = mk(0, 8192, 0,   0, 0, 8192,  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[2] = mk(0, 0, 8192,   0, 8192, 0,  1, 1, 160, 160, 240, 90, 45, 90, 160, 240, 45, 90, 3600);
    vt[3] = mk(40960, 40960, 40960, 0, 8192, -8192, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[4] = mk(-24576, 8192, 0, 0, 0, 8192, 0, 1, -80, 240, 160, 90, 90, 45, 0, 240, 45, 90, -14400);
    vt[5] = mk(0, 4096, 8192, 0, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[6] = mk(0, 8192, 0,   0, 0, 524287, 0, 1, 160, 240, 160, 90, 90, -2048, 160, 240, 0, 90, -171040);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready_a", ready_a, 1);
    chk("rst_valid_a", valid_a, 0);
    chk_res("rst_data_a", res_a, '0);
    chk("rst_cnt_a", {cnto_a, cntc_a}, 0);
    chk("rst_ready_b", ready_b, 1);
    chk("rst_valid_b", valid_b, 0);
    chk_res("rst_data_b", res_b, '0);
    chk("rst_cnt_b", {cnto_b, cntc_b}, 0);

    for (int i = 0; i < 7; i++) run_vec(vt[i], 0);

    // Long stall in HOLD with valid_in toggling and input data changing.
    run_vec(vt[4], 10);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 3; i++) begin
        rx[i] = int'($urandom_range(0, 40000)) - 20000;
        ry[i] = int'($urandom_range(0, 32000)) - 16000;
      end
      run_vec(model(rx, ry, 1'($urandom_range(0, 1))), int'($urandom_range(0, 2)));
    end

    // Reset while the triangle sits in AREA: it must vanish without a count.
    sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x_in[i] = 18'(vt[0].x[i]); y_in[i] = 20'(vt[0].y[i]);
    end
    tb_valid = 1'b1;
    @(posedge clk); #1;
    tb_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_out[0] = 0; exp_out[1] = 0; exp_cull[0] = 0; exp_cull[1] = 0;
    chk("abort_ready", ready_a, 1);
    chk("abort_valid", valid_a, 0);
    chk("abort_cnt_a", {cnto_a, cntc_a}, 0);
    chk("abort_cnt_b", {cnto_b, cntc_b}, 0);
    lost = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (valid_a) lost = 1;
    end
    chk("abort_no_output", lost, 0);

    run_vec(vt[0], 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
